// File: rtl/logic_pkg.sv
// Shared encodings for the logic_gate_pipe block: reduction modes and FSM states.
package logic_pkg;

    // Bitwise function applied across operands (and across beats when folding).
    typedef enum logic [1:0] {
        MODE_AND  = 2'd0,
        MODE_OR   = 2'd1,
        MODE_XOR  = 2'd2,
        MODE_NAND = 2'd3
    } mode_t;

    // IDLE: next beat starts a new result; ACCUM: folding a multi-beat packet.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/logic_reduce.sv
// Combinational bitwise reduction of NUM_IN operands of WIDTH bits.
// NAND is reduced as AND here; the top applies the inversion once at the end.
module logic_reduce
    import logic_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] operands,
    input  logic [1:0]              mode,
    output logic [WIDTH-1:0]        r
);

    logic [NUM_IN-1:0][WIDTH-1:0] ops;
    logic [WIDTH-1:0]             red;

    assign ops = operands;
    assign r   = red;

    // Walk the operand list, folding each one in with the selected function.
    always_comb begin
        red = ops[0];
        for (int k = 1; k < NUM_IN; k++) begin
            case (mode)
                MODE_OR:  red = red | ops[k];
                MODE_XOR: red = red ^ ops[k];
                default:  red = red & ops[k];
            endcase
        end
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered, handshaked N-input bitwise gate with optional multi-beat folding.
// One output register; a stalled output back-pressures the whole input side.
module logic_gate_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    input  logic [NUM_IN*WIDTH-1:0] In_Data,
    input  logic [1:0]              In_Mode,
    input  logic                    In_Accum,
    input  logic                    In_Last,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic [WIDTH-1:0]        Out_Data,
    output logic [CNT_W-1:0]        Out_Count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic [1:0]       red_mode;
    logic [WIDTH-1:0] red_r;
    logic [WIDTH-1:0] fold;
    logic [CNT_W-1:0] cnt_inc;
    logic             load;
    logic [WIDTH-1:0] ld_data;
    logic [CNT_W-1:0] ld_cnt;

    assign In_Ready = !Out_Valid | Out_Ready;
    assign accept   = In_Valid & In_Ready;

    // Inside a packet the latched mode governs every beat, not the live In_Mode.
    assign red_mode = (state == ST_ACCUM) ? mode_q : In_Mode;

    logic_reduce #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_reduce (
        .operands (In_Data),
        .mode     (red_mode),
        .r        (red_r)
    );

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // Fold the current beat into the running accumulator.
    always_comb begin
        case (mode_q)
            MODE_OR:  fold = acc_q | red_r;
            MODE_XOR: fold = acc_q ^ red_r;
            default:  fold = acc_q & red_r;
        endcase
    end

    // Next-state, accumulator update and output-load decision.
    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        ld_data = '0;
        ld_cnt  = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (In_Accum && !In_Last) begin
                        mode_d  = In_Mode;
                        acc_d   = red_r;
                        cnt_d   = CNT_ONE;
                        state_d = ST_ACCUM;
                    end else begin
                        load    = 1'b1;
                        ld_data = (In_Mode == MODE_NAND) ? ~red_r : red_r;
                        ld_cnt  = CNT_ONE;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    if (In_Last) begin
                        load    = 1'b1;
                        ld_data = (mode_q == MODE_NAND) ? ~fold : fold;
                        ld_cnt  = cnt_inc;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        acc_d = fold;
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and packet accumulator registers; reset drops any partial packet.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= ST_IDLE;
            mode_q <= MODE_AND;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_d;
            mode_q <= mode_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end

    // Output register: a new result wins over a drain in the same cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Out_Valid <= 1'b0;
            Out_Data  <= '0;
            Out_Count <= '0;
        end else if (load) begin
            Out_Valid <= 1'b1;
            Out_Data  <= ld_data;
            Out_Count <= ld_cnt;
        end else if (Out_Valid && Out_Ready) begin
            Out_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: two instances (CNT_W=8 and CNT_W=2)
// share the stimulus so counter saturation is exercised alongside normal runs.
module tb_logic_gate_pipe;
    import logic_pkg::*;

    localparam int W = 8;
    localparam int N = 2;

    logic           Clk = 1'b0;
    logic           Rst;
    logic           In_Valid;
    logic           In_Ready;
    logic [N*W-1:0] In_Data;
    logic [1:0]     In_Mode;
    logic           In_Accum;
    logic           In_Last;
    logic           Out_Valid;
    logic           Out_Ready;
    logic [W-1:0]   Out_Data;
    logic [7:0]     Out_Count;

    logic           sat_in_ready;
    logic           sat_out_valid;
    logic [W-1:0]   sat_out_data;
    logic [1:0]     sat_out_count;

    always #5 Clk = ~Clk;

    logic_gate_pipe #(.WIDTH(W), .NUM_IN(N), .CNT_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_Data(In_Data), .In_Mode(In_Mode), .In_Accum(In_Accum), .In_Last(In_Last),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data), .Out_Count(Out_Count)
    );

    logic_gate_pipe #(.WIDTH(W), .NUM_IN(N), .CNT_W(2)) dut_sat (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(sat_in_ready),
        .In_Data(In_Data), .In_Mode(In_Mode), .In_Accum(In_Accum), .In_Last(In_Last),
        .Out_Valid(sat_out_valid), .Out_Ready(Out_Ready), .Out_Data(sat_out_data),
        .Out_Count(sat_out_count)
    );

    typedef struct {
        logic [W-1:0] data;
        int           beats;
    } exp_t;

    exp_t         expq[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    bit           rand_rdy = 1'b0;

    // Reference model: collect every operand of a packet, reduce them all at the end.
    bit           in_pkt = 1'b0;
    logic [1:0]   pkt_mode;
    logic [W-1:0] pkt_ops[$];
    int           pkt_beats;

    function automatic logic [7:0] sat8(input int n);
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    function automatic logic [1:0] sat2(input int n);
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    task automatic model_reset();
        expq.delete();
        pkt_ops.delete();
        in_pkt    = 1'b0;
        pkt_beats = 0;
    endtask

    task automatic model_beat(input logic [N*W-1:0] d, input logic [1:0] m,
                              input bit acc, input bit last);
        logic [W-1:0] r;
        bit           done;
        if (!in_pkt) begin
            pkt_mode  = m;
            pkt_ops.delete();
            pkt_beats = 0;
        end
        for (int k = 0; k < N; k++) pkt_ops.push_back(d[k*W +: W]);
        pkt_beats++;
        done = in_pkt ? last : (!acc || last);
        if (!done) begin
            in_pkt = 1'b1;
        end else begin
            r = pkt_ops[0];
            for (int i = 1; i < pkt_ops.size(); i++) begin
                case (pkt_mode)
                    2'd1:    r = r | pkt_ops[i];
                    2'd2:    r = r ^ pkt_ops[i];
                    default: r = r & pkt_ops[i];
                endcase
            end
            if (pkt_mode == 2'd3) r = ~r;
            expq.push_back('{data: r, beats: pkt_beats});
            in_pkt = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every transfer on the output is checked against the scoreboard.
    always @(negedge Clk) begin
        if (!Rst && Out_Valid && Out_Ready) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got data=%h count=%0d, required no output",
                         Out_Data, Out_Count);
            end else begin
                mon_e = expq.pop_front();
                if (Out_Data !== mon_e.data || Out_Count !== sat8(mon_e.beats) ||
                    sat_out_valid !== 1'b1 || sat_out_data !== mon_e.data ||
                    sat_out_count !== sat2(mon_e.beats) || sat_in_ready !== In_Ready) begin
                    errors++;
                    $display("FAIL scoreboard: got data=%h cnt=%0d sat_v=%b sat_data=%h sat_cnt=%0d, required data=%h cnt=%0d sat_cnt=%0d",
                             Out_Data, Out_Count, sat_out_valid, sat_out_data, sat_out_count,
                             mon_e.data, sat8(mon_e.beats), sat2(mon_e.beats));
                end
            end
        end
    end

    task automatic send(input logic [N*W-1:0] d, input logic [1:0] m,
                        input bit acc, input bit last);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b1;
        In_Valid = 1'b1;
        In_Data  = d;
        In_Mode  = m;
        In_Accum = acc;
        In_Last  = last;
        if (rand_rdy) Out_Ready = ($urandom_range(0, 3) != 0);
        forever begin
            @(negedge Clk);
            if (In_Ready) break;
            t++;
            if (t > 100) begin
                checks++;
                errors++;
                ok = 1'b0;
                $display("FAIL accept_timeout: got In_Ready=0 for %0d cycles, required 1", t);
                break;
            end
            @(posedge Clk);
            #1;
            if (rand_rdy) Out_Ready = ($urandom_range(0, 3) != 0);
        end
        if (ok) model_beat(d, m, acc, last);
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
    endtask

    task automatic expect_out(input logic [W-1:0] d, input int n);
        @(negedge Clk);
        chk("out_valid", 32'(Out_Valid), 32'd1);
        chk("out_data", 32'(Out_Data), 32'(d));
        chk("out_count", 32'(Out_Count), 32'(sat8(n)));
        chk("sat_count", 32'(sat_out_count), 32'(sat2(n)));
        @(posedge Clk);
        #1;
    endtask

    task automatic reset_now();
        @(posedge Clk);
        #3;
        Rst = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(Out_Valid), 32'd0);
        chk("rst_out_data", 32'(Out_Data), 32'd0);
        chk("rst_out_count", 32'(Out_Count), 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(In_Ready), 32'd1);
    endtask

    initial begin
        logic [N*W-1:0] rd;
        Rst       = 1'b1;
        In_Valid  = 1'b0;
        In_Data   = '0;
        In_Mode   = 2'd0;
        In_Accum  = 1'b0;
        In_Last   = 1'b0;
        Out_Ready = 1'b1;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        chk("init_out_valid", 32'(Out_Valid), 32'd0);
        chk("init_out_count", 32'(Out_Count), 32'd0);
        Rst = 1'b0;
        #1;
        chk("init_in_ready", 32'(In_Ready), 32'd1);

        // Single beats, one per mode.
        send({8'h0F, 8'hA5}, 2'd0, 1'b0, 1'b0); expect_out(8'h05, 1);
        send({8'h0F, 8'hA5}, 2'd1, 1'b0, 1'b0); expect_out(8'hAF, 1);
        send({8'h0F, 8'hA5}, 2'd2, 1'b0, 1'b0); expect_out(8'hAA, 1);
        send({8'h0F, 8'hA5}, 2'd3, 1'b0, 1'b0); expect_out(8'hFA, 1);
        // Accumulate with Last on a single beat: still one-beat result.
        send({8'h3C, 8'hF0}, 2'd1, 1'b1, 1'b1); expect_out(8'hFC, 1);

        // XOR packet; mode flips to AND mid-packet and must be ignored.
        send({8'h02, 8'h01}, 2'd2, 1'b1, 1'b0);
        chk("no_early_out", 32'(Out_Valid), 32'd0);
        send({8'h00, 8'h04}, 2'd0, 1'b1, 1'b0);
        send({8'h10, 8'h80}, 2'd2, 1'b1, 1'b1);
        expect_out(8'h97, 3);

        // Back-pressure: pending result holds input off and stays stable.
        Out_Ready = 1'b0;
        send({8'h0F, 8'hF0}, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("bp_in_ready", 32'(In_Ready), 32'd0);
            chk("bp_data_stable", 32'(Out_Data), 32'hFF);
        end
        @(posedge Clk);
        #1;
        Out_Ready = 1'b1;
        send({8'h33, 8'hFF}, 2'd0, 1'b0, 1'b0);
        expect_out(8'h33, 1);

        // Reset with a result pending.
        Out_Ready = 1'b0;
        send({8'h55, 8'hAA}, 2'd2, 1'b0, 1'b0);
        reset_now();
        Out_Ready = 1'b1;

        // Saturation: six all-ones AND beats.
        for (int i = 0; i < 6; i++) send({8'hFF, 8'hFF}, 2'd0, 1'b1, (i == 5));
        expect_out(8'hFF, 6);

        // Reset in the middle of a packet, then a clean single beat.
        send({8'h0F, 8'h01}, 2'd1, 1'b1, 1'b0);
        send({8'h0F, 8'h02}, 2'd1, 1'b1, 1'b0);
        reset_now();
        send({8'h3C, 8'hF0}, 2'd0, 1'b0, 1'b0);
        expect_out(8'h30, 1);

        // Random traffic with random output stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rd = N*W'($urandom);
            send(rd, 2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) < 3));
            if ($urandom_range(0, 7) == 0) begin
                @(posedge Clk);
                #1;
                Out_Ready = ($urandom_range(0, 3) != 0);
            end
        end
        if (in_pkt) send(N*W'($urandom), 2'd0, 1'b1, 1'b1);
        rand_rdy  = 1'b0;
        Out_Ready = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
